// File: rtl/dmem_arbiter_if.sv
// Requester-side bus for one port of the data-memory arbiter.
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: CPU port 0 has priority,
// debug port 1 is protected from starvation by a wait counter that forces a grant.
module dmem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     p0,
    dmem_arbiter_if.slave     p1,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    // A byte address is legal only if nothing above the word-index field is set.
    function automatic logic in_range(input logic [31:0] addr);
        return (addr >> (ADDR_W + 2)) == 32'd0;
    endfunction

    logic              gnt0_s;
    logic              gnt1_s;
    logic              in_range0_s;
    logic              in_range1_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [31:0]       mem_wdata_s;
    logic [3:0]        wait_cnt_r;
    logic [3:0]        wait_cnt_nxt_s;
    logic              force_r;
    logic              force_nxt_s;
    logic              rvalid0_r;
    logic              rvalid1_r;
    logic              err_r;
    logic [31:0]       rdata0_r;
    logic [31:0]       rdata1_r;

    assign in_range0_s = in_range(p0.addr);
    assign in_range1_s = in_range(p1.addr);

    // Grant decision: a forced port 1 beats port 0, otherwise port 0 wins.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (rst) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (force_r && p1.req) begin
            gnt1_s = 1'b1;
        end else if (p0.req) begin
            gnt0_s = 1'b1;
        end else if (p1.req) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Memory drive from the granted port; when idle the address parks on port 0.
    always_comb begin
        mem_addr_s  = p0.addr[ADDR_W+1:2];
        mem_wdata_s = 32'd0;
        mem_we_s    = 1'b0;
        if (gnt1_s) begin
            mem_addr_s  = p1.addr[ADDR_W+1:2];
            mem_wdata_s = p1.wdata;
            mem_we_s    = p1.we && in_range1_s;
        end else if (gnt0_s) begin
            mem_addr_s  = p0.addr[ADDR_W+1:2];
            mem_wdata_s = p0.wdata;
            mem_we_s    = p0.we && in_range0_s;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Starvation tracking: force is raised on the edge the counter reaches the limit.
    always_comb begin
        wait_cnt_nxt_s = wait_cnt_r;
        force_nxt_s    = force_r;
        if (!p1.req || gnt1_s) begin
            wait_cnt_nxt_s = 4'd0;
        end else if (wait_cnt_r < WAIT_LIMIT) begin
            wait_cnt_nxt_s = wait_cnt_r + 4'd1;
        end else begin
            wait_cnt_nxt_s = wait_cnt_r;
        end
        if (gnt1_s) begin
            force_nxt_s = 1'b0;
        end else if (p1.req && (wait_cnt_nxt_s == WAIT_LIMIT)) begin
            force_nxt_s = 1'b1;
        end else begin
            force_nxt_s = force_r;
        end
    end

    // Registered read return, error pulse and arbitration state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= 4'd0;
            force_r    <= 1'b0;
            rvalid0_r  <= 1'b0;
            rvalid1_r  <= 1'b0;
            err_r      <= 1'b0;
            rdata0_r   <= 32'd0;
            rdata1_r   <= 32'd0;
        end else begin
            wait_cnt_r <= wait_cnt_nxt_s;
            force_r    <= force_nxt_s;
            rvalid0_r  <= gnt0_s && !p0.we;
            rvalid1_r  <= gnt1_s && !p1.we;
            err_r      <= (gnt0_s && !in_range0_s) || (gnt1_s && !in_range1_s);
            if (gnt0_s && !p0.we) begin
                rdata0_r <= in_range0_s ? mem_rdata : 32'd0;
            end else begin
                rdata0_r <= rdata0_r;
            end
            if (gnt1_s && !p1.we) begin
                rdata1_r <= in_range1_s ? mem_rdata : 32'd0;
            end else begin
                rdata1_r <= rdata1_r;
            end
        end
    end

    assign p0.gnt    = gnt0_s;
    assign p1.gnt    = gnt1_s;
    assign p0.rvalid = rvalid0_r;
    assign p1.rvalid = rvalid1_r;
    assign p0.rdata  = rdata0_r;
    assign p1.rdata  = rdata1_r;
    assign err       = err_r;
    assign mem_addr  = mem_addr_s;
    assign mem_we    = mem_we_s;
    assign mem_wdata = mem_wdata_s;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected read data is queued at grant time
// and popped when the registered read return appears.
module tb_dmem_arbiter;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_init;
    logic [31:0]       mem     [0:255];
    logic [31:0]       ref_mem [0:255];
    logic [31:0]       exp0_q[$];
    logic [31:0]       exp1_q[$];
    logic [31:0]       e;
    int                vectors = 0;
    int                miscompares = 0;

    dmem_arbiter_if p0_if ();
    dmem_arbiter_if p1_if ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .p0        (p0_if),
        .p1        (p1_if),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pattern(input int i);
        return 32'hA5A5_0000 | 32'(i);
    endfunction

    // Memory behind the arbiter: combinational read, write at the clock edge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= pattern(i);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic drive(input int port, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            p0_if.req = req; p0_if.we = we; p0_if.addr = addr; p0_if.wdata = wdata;
        end else begin
            p1_if.req = req; p1_if.we = we; p1_if.addr = addr; p1_if.wdata = wdata;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();
        for (int c = 0; c < 2; c++) begin
            if (c == 1) drive(0, 1'b1, 1'b1, 32'h10, 32'h55);
            @(negedge clk);
            vectors++;
            if ({p0_if.gnt, p1_if.gnt, mem_we, p0_if.rvalid, p1_if.rvalid, err} !== 6'b0) begin
                miscompares++;
                $display("FAIL rst_ctrl: got %b want 000000", {p0_if.gnt, p1_if.gnt, mem_we, p0_if.rvalid, p1_if.rvalid, err});
            end
            vectors++;
            if ({p0_if.rdata, p1_if.rdata} !== 64'd0) begin
                miscompares++;
                $display("FAIL rst_rdata: got %h want 0", {p0_if.rdata, p1_if.rdata});
            end
            next_cycle();
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors++;
            if ({p0_if.gnt, p1_if.gnt, mem_we, p0_if.rvalid, p1_if.rvalid, err} !== 6'b0) begin
                miscompares++;
                $display("FAIL idle_ctrl: got %b want 000000", {p0_if.gnt, p1_if.gnt, mem_we, p0_if.rvalid, p1_if.rvalid, err});
            end
            next_cycle();
        end
    endtask

    task automatic test_write_read();
        drive(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        vectors++;
        if ({p0_if.gnt, p1_if.gnt, mem_we, mem_addr, mem_wdata} !== {3'b101, 8'd4, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL wr_drive: got %b %b %b %h %h want 1 0 1 04 deadbeef", p0_if.gnt, p1_if.gnt, mem_we, mem_addr, mem_wdata);
        end
        ref_mem[4] = 32'hDEADBEEF;
        next_cycle();
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        vectors++;
        if ({p0_if.gnt, mem_we, p0_if.rvalid, mem_addr} !== {3'b100, 8'd4}) begin
            miscompares++;
            $display("FAIL rd_drive: got %b %b %b %h want 1 0 0 04", p0_if.gnt, mem_we, p0_if.rvalid, mem_addr);
        end
        exp0_q.push_back(ref_mem[4]);
        next_cycle();
        drive(0, 1'b0, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        e = exp0_q.pop_front();
        vectors++;
        if ({p0_if.rvalid, err, p0_if.rdata} !== {2'b10, e}) begin
            miscompares++;
            $display("FAIL rd_return: got %b %b %h want 1 0 %h", p0_if.rvalid, err, p0_if.rdata, e);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if ({p0_if.rvalid, p0_if.rdata} !== {1'b0, e}) begin
            miscompares++;
            $display("FAIL rd_hold: got %b %h want 0 %h", p0_if.rvalid, p0_if.rdata, e);
        end
        next_cycle();
    endtask

    task automatic test_priority();
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h4, 32'h0);
        @(negedge clk);
        vectors++;
        if ({p0_if.gnt, p1_if.gnt, mem_addr} !== {2'b10, 8'd0}) begin
            miscompares++;
            $display("FAIL prio_first: got %b %b %h want 1 0 00", p0_if.gnt, p1_if.gnt, mem_addr);
        end
        exp0_q.push_back(ref_mem[0]);
        next_cycle();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        e = exp0_q.pop_front();
        vectors++;
        if ({p0_if.gnt, p1_if.gnt, mem_addr, p0_if.rvalid, p0_if.rdata} !== {2'b01, 8'd1, 1'b1, e}) begin
            miscompares++;
            $display("FAIL prio_second: got %b %b %h %b %h want 0 1 01 1 %h", p0_if.gnt, p1_if.gnt, mem_addr, p0_if.rvalid, p0_if.rdata, e);
        end
        exp1_q.push_back(ref_mem[1]);
        next_cycle();
        drive(1, 1'b0, 1'b0, 32'h4, 32'h0);
        @(negedge clk);
        e = exp1_q.pop_front();
        vectors++;
        if ({p0_if.rvalid, p1_if.rvalid, p1_if.rdata} !== {2'b01, e}) begin
            miscompares++;
            $display("FAIL prio_rvalid1: got %b %b %h want 0 1 %h", p0_if.rvalid, p1_if.rvalid, p1_if.rdata, e);
        end
        next_cycle();
    endtask

    task automatic test_starvation();
        logic pg0, pg1, eg0, eg1;
        pg0 = 1'b0;
        pg1 = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h8, 32'h0);
        drive(1, 1'b1, 1'b0, 32'hC, 32'h0);
        for (int c = 1; c <= 7; c++) begin
            if (c == 6) drive(1, 1'b0, 1'b0, 32'hC, 32'h0);
            if (c == 7) drive(1, 1'b1, 1'b0, 32'hC, 32'h0);
            eg0 = (c != 5);
            eg1 = (c == 5);
            @(negedge clk);
            vectors++;
            if ({p0_if.gnt, p1_if.gnt, p0_if.rvalid, p1_if.rvalid} !== {eg0, eg1, pg0, pg1}) begin
                miscompares++;
                $display("FAIL starve_c%0d: got %b%b%b%b want %b%b%b%b", c, p0_if.gnt, p1_if.gnt, p0_if.rvalid, p1_if.rvalid, eg0, eg1, pg0, pg1);
            end
            if (pg0) begin
                e = exp0_q.pop_front();
                vectors++;
                if (p0_if.rdata !== e) begin
                    miscompares++;
                    $display("FAIL starve_rdata0_c%0d: got %h want %h", c, p0_if.rdata, e);
                end
            end
            if (pg1) begin
                e = exp1_q.pop_front();
                vectors++;
                if (p1_if.rdata !== e) begin
                    miscompares++;
                    $display("FAIL starve_rdata1_c%0d: got %h want %h", c, p1_if.rdata, e);
                end
            end
            if (eg0) exp0_q.push_back(ref_mem[2]);
            if (eg1) exp1_q.push_back(ref_mem[3]);
            pg0 = eg0;
            pg1 = eg1;
            next_cycle();
        end
        drive(0, 1'b0, 1'b0, 32'h8, 32'h0);
        drive(1, 1'b0, 1'b0, 32'hC, 32'h0);
        @(negedge clk);
        e = exp0_q.pop_front();
        vectors++;
        if ({p0_if.rvalid, p0_if.rdata} !== {1'b1, e}) begin
            miscompares++;
            $display("FAIL starve_tail: got %b %h want 1 %h", p0_if.rvalid, p0_if.rdata, e);
        end
        next_cycle();
    endtask

    task automatic test_out_of_range();
        drive(0, 1'b1, 1'b1, 32'h400, 32'h1234);
        @(negedge clk);
        vectors++;
        if ({p0_if.gnt, mem_we, err} !== 3'b100) begin
            miscompares++;
            $display("FAIL oor_wr: got %b %b %b want 1 0 0", p0_if.gnt, mem_we, err);
        end
        next_cycle();
        drive(0, 1'b1, 1'b0, 32'h400, 32'h0);
        @(negedge clk);
        vectors++;
        if ({p0_if.gnt, mem_we, err, p0_if.rvalid} !== 4'b1010) begin
            miscompares++;
            $display("FAIL oor_rd: got %b %b %b %b want 1 0 1 0", p0_if.gnt, mem_we, err, p0_if.rvalid);
        end
        exp0_q.push_back(32'd0);
        next_cycle();
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        e = exp0_q.pop_front();
        vectors++;
        if ({err, p0_if.rvalid, p0_if.rdata} !== {2'b11, e}) begin
            miscompares++;
            $display("FAIL oor_rdata: got %b %b %h want 1 1 %h", err, p0_if.rvalid, p0_if.rdata, e);
        end
        exp0_q.push_back(ref_mem[0]);
        next_cycle();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        e = exp0_q.pop_front();
        vectors++;
        if ({err, p0_if.rvalid, p0_if.rdata} !== {2'b01, e}) begin
            miscompares++;
            $display("FAIL oor_word0: got %b %b %h want 0 1 %h", err, p0_if.rvalid, p0_if.rdata, e);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        drive(1, 1'b1, 1'b1, 32'h20, 32'h600DF00D);
        @(negedge clk);
        vectors++;
        if ({p1_if.gnt, mem_we, mem_addr, mem_wdata} !== {2'b11, 8'd8, 32'h600DF00D}) begin
            miscompares++;
            $display("FAIL b2b_wr: got %b %b %h %h want 1 1 08 600df00d", p1_if.gnt, mem_we, mem_addr, mem_wdata);
        end
        ref_mem[8] = 32'h600DF00D;
        next_cycle();
        drive(1, 1'b1, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        vectors++;
        if ({p1_if.gnt, mem_we, p1_if.rvalid} !== 3'b100) begin
            miscompares++;
            $display("FAIL b2b_rd1: got %b %b %b want 1 0 0", p1_if.gnt, mem_we, p1_if.rvalid);
        end
        exp1_q.push_back(ref_mem[8]);
        next_cycle();
        drive(1, 1'b1, 1'b0, 32'h24, 32'h0);
        @(negedge clk);
        e = exp1_q.pop_front();
        vectors++;
        if ({p1_if.gnt, p1_if.rvalid, p1_if.rdata} !== {2'b11, e}) begin
            miscompares++;
            $display("FAIL b2b_rd2: got %b %b %h want 1 1 %h", p1_if.gnt, p1_if.rvalid, p1_if.rdata, e);
        end
        exp1_q.push_back(ref_mem[9]);
        next_cycle();
        drive(1, 1'b0, 1'b0, 32'h24, 32'h0);
        drive(0, 1'b0, 1'b0, 32'h3C, 32'h77);
        @(negedge clk);
        e = exp1_q.pop_front();
        vectors++;
        if ({p1_if.rvalid, p1_if.rdata, mem_addr, mem_wdata, mem_we} !== {1'b1, e, 8'd15, 32'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_tail: got %b %h %h %h %b want 1 %h 0f 0 0", p1_if.rvalid, p1_if.rdata, mem_addr, mem_wdata, mem_we, e);
        end
        next_cycle();
    endtask

    task automatic test_reset_during_read();
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        vectors++;
        if (p0_if.gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL rstrd_gnt: got %b want 1", p0_if.gnt);
        end
        next_cycle();
        drive(0, 1'b0, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b1, 1'b1, 32'h30, 32'hCAFEF00D);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({p1_if.gnt, mem_we} !== 2'b00) begin
            miscompares++;
            $display("FAIL rstrd_wr_mask: got %b %b want 0 0", p1_if.gnt, mem_we);
        end
        next_cycle();
        rst = 1'b0;
        drive(1, 1'b0, 1'b0, 32'h30, 32'h0);
        @(negedge clk);
        vectors++;
        if ({p0_if.rvalid, p0_if.rdata, err} !== {1'b0, 32'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL rstrd_clear: got %b %h %b want 0 0 0", p0_if.rvalid, p0_if.rdata, err);
        end
        next_cycle();
        drive(0, 1'b1, 1'b0, 32'h30, 32'h0);
        exp0_q.push_back(ref_mem[12]);
        next_cycle();
        drive(0, 1'b0, 1'b0, 32'h30, 32'h0);
        @(negedge clk);
        e = exp0_q.pop_front();
        vectors++;
        if ({p0_if.rvalid, p0_if.rdata} !== {1'b1, e}) begin
            miscompares++;
            $display("FAIL rstrd_nocommit: got %b %h want 1 %h", p0_if.rvalid, p0_if.rdata, e);
        end
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        mem_init = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = pattern(i);
        test_reset();
        mem_init = 1'b0;
        test_write_read();
        test_priority();
        test_starvation();
        test_out_of_range();
        test_back_to_back();
        test_reset_during_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
